tt_sweep: RTL and testbench

TT_SWEEP -- requirements
Module: tt_sweep

---
 rtl/tt_pkg.sv | 16 +
 rtl/tt_lut.sv | 14 +
 rtl/tt_sweep.sv | 112 +++++++++++
 tb/tb_tt_sweep.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared types and encodings for the truth-table sweep engine.
package tt_pkg;

    // Operation sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        SWEEP = 2'd2,
        FIN   = 2'd3
    } state_e;

    // Operation select encodings, sampled with start
    localparam logic MODE_EVAL  = 1'b0;
    localparam logic MODE_SWEEP = 1'b1;

endpackage : tt_pkg

// File: rtl/tt_lut.sv
// Combinational truth-table bit select: y = table[idx].
module tt_lut #(
    parameter  int unsigned N_IN  = 4,
    localparam int unsigned TBL_W = 2 ** N_IN
) (
    input  logic [TBL_W-1:0] tbl_i,
    input  logic [N_IN-1:0]  idx_i,
    output logic             y_o
);

    // Pure mux, no state
    assign y_o = tbl_i[idx_i];

endmodule : tt_lut

// File: rtl/tt_sweep.sv
// Truth-table engine: single evaluate or full sweep of a loaded table,
// streamed out as valid/ready beats with a running count of ones.
module tt_sweep
    import tt_pkg::*;
#(
    parameter  int unsigned N_IN  = 4,
    localparam int unsigned TBL_W = 2 ** N_IN,
    localparam int unsigned CNT_W = N_IN + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [TBL_W-1:0] cfg_table,
    input  logic             start,
    input  logic             mode,
    input  logic [N_IN-1:0]  eval_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_IN-1:0]  out_idx,
    output logic             out_y,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] ones_cnt
);

    state_e             state_q, state_d;
    logic [TBL_W-1:0]   tbl_q, tbl_d;
    logic [N_IN-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lut_y;
    logic               accept;

    // Table bit for the current index
    tt_lut #(.N_IN(N_IN)) u_lut (
        .tbl_i (tbl_q),
        .idx_i (idx_q),
        .y_o   (lut_y)
    );

    // Output decode straight from the state and index registers
    assign out_valid = (state_q == EVAL) || (state_q == SWEEP);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign out_idx   = idx_q;
    assign out_y     = lut_y & out_valid;
    assign ones_cnt  = cnt_q;
    assign accept    = out_valid & out_ready;

    // State, table, index and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tbl_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tbl_q   <= tbl_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; config and start are only honoured in IDLE
    always_comb begin
        state_d = state_q;
        tbl_d   = tbl_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    tbl_d = cfg_table;
                end
                if (start) begin
                    cnt_d = '0;
                    if (mode == MODE_SWEEP) begin
                        idx_d   = '0;
                        state_d = SWEEP;
                    end else begin
                        idx_d   = eval_in;
                        state_d = EVAL;
                    end
                end
            end
            EVAL: begin
                if (accept) begin
                    cnt_d   = cnt_q + CNT_W'(lut_y);
                    state_d = FIN;
                end
            end
            SWEEP: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(lut_y);
                    // Last code ends the sweep without wrapping the index
                    if (idx_q == N_IN'(TBL_W - 1)) begin
                        state_d = FIN;
                    end else begin
                        idx_d = idx_q + N_IN'(1);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule : tt_sweep

// File: tb/tb_tt_sweep.sv
// Scoreboard bench for tt_sweep at N_IN = 4, 2 and 6.
module tb_tt_sweep;
    import tt_pkg::*;

    typedef struct {
        int inst;
        int idx;
        int y;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  we, st, md, rdy;
    logic [63:0] ctab;
    logic [5:0]  ein;

    logic        v4, y4, b4, d4;
    logic [3:0]  idx4;
    logic [4:0]  cnt4;
    logic        v2, y2, b2, d2;
    logic [1:0]  idx2;
    logic [2:0]  cnt2;
    logic        v6, y6, b6, d6;
    logic [5:0]  idx6;
    logic [6:0]  cnt6;

    logic [2:0]  ov, oy, ob, od;
    logic [5:0]  oidx [3];
    logic [6:0]  ocnt [3];

    int          errors = 0;
    int          checks = 0;
    logic [63:0] mtbl [3];
    beat_t       exp_q [$];
    bit          hold [3];
    int          hidx [3];
    int          hy [3];
    beat_t       mon_e;

    always #5 clk = ~clk;

    tt_sweep #(.N_IN(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .cfg_we(we[0]), .cfg_table(ctab[15:0]),
        .start(st[0]), .mode(md[0]), .eval_in(ein[3:0]), .out_valid(v4),
        .out_ready(rdy[0]), .out_idx(idx4), .out_y(y4), .busy(b4),
        .done(d4), .ones_cnt(cnt4)
    );

    tt_sweep #(.N_IN(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .cfg_we(we[1]), .cfg_table(ctab[3:0]),
        .start(st[1]), .mode(md[1]), .eval_in(ein[1:0]), .out_valid(v2),
        .out_ready(rdy[1]), .out_idx(idx2), .out_y(y2), .busy(b2),
        .done(d2), .ones_cnt(cnt2)
    );

    tt_sweep #(.N_IN(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .cfg_we(we[2]), .cfg_table(ctab),
        .start(st[2]), .mode(md[2]), .eval_in(ein), .out_valid(v6),
        .out_ready(rdy[2]), .out_idx(idx6), .out_y(y6), .busy(b6),
        .done(d6), .ones_cnt(cnt6)
    );

    // Gather the three instances into indexable views
    always_comb begin
        ov      = {v6, v2, v4};
        oy      = {y6, y2, y4};
        ob      = {b6, b2, b4};
        od      = {d6, d2, d4};
        oidx[0] = 6'(idx4);
        oidx[1] = 6'(idx2);
        oidx[2] = idx6;
        ocnt[0] = 7'(cnt4);
        ocnt[1] = 7'(cnt2);
        ocnt[2] = cnt6;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nin(input int i);
        case (i)
            0:       return 4;
            1:       return 2;
            default: return 6;
        endcase
    endfunction

    function automatic int tw(input int i);
        return 1 << nin(i);
    endfunction

    function automatic logic [63:0] tmask(input int i);
        if (tw(i) == 64) return '1;
        return (64'd1 << tw(i)) - 64'd1;
    endfunction

    function automatic bit ready_of(input int pat, input int c);
        case (pat)
            0:       return 1'b1;
            1:       return ((c % 4) == 0) || ((c % 4) == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Monitor: pop and compare on every accepted beat; check hold under backpressure
    initial begin
        for (int i = 0; i < 3; i++) hold[i] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (ov[i]) begin
                    if (hold[i]) begin
                        chk("hold_idx", longint'(oidx[i]), longint'(hidx[i]));
                        chk("hold_y", longint'(oy[i]), longint'(hy[i]));
                    end
                    hold[i] = !rdy[i];
                    hidx[i] = int'(oidx[i]);
                    hy[i]   = int'(oy[i]);
                    if (rdy[i]) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_beat_inst", longint'(i), -1);
                        end else begin
                            mon_e = exp_q.pop_front();
                            chk("beat_inst", longint'(i), longint'(mon_e.inst));
                            chk("beat_idx", longint'(oidx[i]), longint'(mon_e.idx));
                            chk("beat_y", longint'(oy[i]), longint'(mon_e.y));
                        end
                    end
                end else begin
                    hold[i] = 1'b0;
                end
            end
        end
    end

    // One operation on instance i; entered and left at posedge+2
    task automatic run_op(input int i, input bit m, input int ev, input int pat,
                          input bit load, input logic [63:0] newtbl, input bit inject);
        int  ones;
        int  nbeats;
        int  cyc;
        bit  got_done;
        int  cnt_before;
        if (load) begin
            ctab    = newtbl;
            we[i]   = 1'b1;
            mtbl[i] = newtbl & tmask(i);
        end
        ones = 0;
        if (m == MODE_EVAL) begin
            nbeats = 1;
            exp_q.push_back('{i, ev, int'(mtbl[i][ev])});
            ones = int'(mtbl[i][ev]);
        end else begin
            nbeats = tw(i);
            for (int k = 0; k < tw(i); k++) begin
                exp_q.push_back('{i, k, int'(mtbl[i][k])});
                ones += int'(mtbl[i][k]);
            end
        end
        md[i] = m;
        ein   = 6'(ev);
        st[i] = 1'b1;
        @(negedge clk);
        chk("idle_valid", longint'(ov[i]), 0);
        chk("idle_busy", longint'(ob[i]), 0);
        @(posedge clk);
        #2;
        st[i]    = 1'b0;
        we[i]    = 1'b0;
        cyc      = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 600) begin
            rdy[i] = ready_of(pat, cyc);
            if (inject && cyc == 5) begin
                st[i] = 1'b1;
                we[i] = 1'b1;
                ctab  = '0;
                md[i] = ~m;
            end
            if (inject && cyc == 6) begin
                st[i] = 1'b0;
                we[i] = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("valid_latency", longint'(ov[i]), 1);
                chk("busy_running", longint'(ob[i]), 1);
            end
            if (od[i]) got_done = 1'b1;
            else begin
                @(posedge clk);
                #2;
            end
        end
        chk("done_seen", longint'(got_done), 1);
        if (got_done) begin
            chk("fin_valid", longint'(ov[i]), 0);
            chk("fin_busy", longint'(ob[i]), 1);
            chk("ones_cnt", longint'(ocnt[i]), longint'(ones));
            chk("beats_pending", longint'(exp_q.size()), 0);
            if (pat == 0) chk("done_latency", longint'(cyc), longint'(nbeats + 1));
        end
        exp_q.delete();
        @(posedge clk);
        #2;
        rdy[i]     = 1'($urandom_range(0, 1));
        cnt_before = ones;
        @(negedge clk);
        chk("back_idle_busy", longint'(ob[i]), 0);
        chk("back_idle_done", longint'(od[i]), 0);
        chk("ones_hold", longint'(ocnt[i]), longint'(cnt_before));
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_valid"}, longint'(ov[i]), 0);
            chk({tag, "_y"}, longint'(oy[i]), 0);
            chk({tag, "_idx"}, longint'(oidx[i]), 0);
            chk({tag, "_busy"}, longint'(ob[i]), 0);
            chk({tag, "_done"}, longint'(od[i]), 0);
            chk({tag, "_cnt"}, longint'(ocnt[i]), 0);
        end
    endtask

    // Stimulus sequence
    initial begin
        bit found;
        rst_n = 1'b0;
        we    = '0;
        st    = '0;
        md    = '0;
        rdy   = '0;
        ctab  = '0;
        ein   = '0;
        for (int i = 0; i < 3; i++) mtbl[i] = '0;
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Directed sweep and evaluate on the 16-entry table
        run_op(0, MODE_SWEEP, 0, 0, 1'b1, 64'hA5C3, 1'b0);
        run_op(0, MODE_EVAL, 13, 0, 1'b0, '0, 1'b0);
        // Full-scale count under 1,0,0,1 backpressure
        run_op(0, MODE_SWEEP, 0, 1, 1'b1, 64'hFFFF, 1'b0);
        // start/cfg_we pulsed mid-sweep are ignored; table re-read afterwards
        run_op(0, MODE_SWEEP, 0, 0, 1'b1, 64'h00FF, 1'b1);
        run_op(0, MODE_SWEEP, 0, 2, 1'b0, '0, 1'b0);
        // Parameter corners
        run_op(1, MODE_SWEEP, 0, 0, 1'b1, 64'h9, 1'b0);
        run_op(2, MODE_SWEEP, 0, 0, 1'b1, '1, 1'b0);
        run_op(2, MODE_EVAL, 63, 1, 1'b0, '0, 1'b0);

        // Randomized operations across all instances
        for (int r = 0; r < 14; r++) begin
            int ri;
            ri = int'($urandom_range(0, 2));
            run_op(ri, 1'($urandom_range(0, 1)), int'($urandom_range(0, tw(ri) - 1)),
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   {$urandom, $urandom}, 1'b0);
        end

        // Reset in the middle of a sweep
        ctab  = 64'hFFFF;
        we[0] = 1'b1;
        md[0] = MODE_SWEEP;
        st[0] = 1'b1;
        for (int k = 0; k <= 5; k++) exp_q.push_back('{0, k, 1});
        @(posedge clk);
        #2;
        st[0]  = 1'b0;
        we[0]  = 1'b0;
        rdy[0] = 1'b1;
        found  = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (ov[0] && oidx[0] == 6'd5) found = 1'b1;
        end
        chk("reach_idx5", longint'(found), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        chk("rst_beats_pending", longint'(exp_q.size()), 0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) mtbl[i] = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_no_done", longint'(od[0]), 0);
            chk("rst_no_valid", longint'(ov[0]), 0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_op(0, MODE_SWEEP, 0, 0, 1'b0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_tt_sweep
